// File: rtl/key_calc_entry.sv
// Keypad entry and arithmetic unit for the calculator datapath: turns scanner key
// levels into press events, builds two decimal operands and computes on '=' or a chained operator.
module key_calc_entry #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             IN_clk,
   input  logic             IN_rst_n,
   input  logic [3:0]       IN_value,
   input  logic             IN_key,
   input  logic             IN_clr,
   output logic [WIDTH-1:0] OUT_display,
   output logic [2:0]       OUT_op,
   output logic [1:0]       OUT_state,
   output logic             OUT_done,
   output logic             OUT_ovf
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {S_A = 2'd0, S_OP = 2'd1, S_B = 2'd2, S_RES = 2'd3} state_t;

   state_t           state;
   logic             key_d;
   logic [WIDTH-1:0] a, b;
   logic [CW-1:0]    cnt;

   logic             ev, is_digit, is_eq, can_add;
   logic [2:0]       new_op;
   logic [WIDTH-1:0] digit_ext, cur, acc, res;
   logic [WIDTH:0]   sum_w;
   logic             res_ovf;

   assign ev        = IN_key & ~key_d;
   assign is_digit  = (IN_value <= 4'd9);
   assign is_eq     = (IN_value == 4'd15);
   // Operator codes 10..14 map onto 1..5 through their low three bits.
   assign new_op    = IN_value[2:0] - 3'd1;
   assign digit_ext = {{(WIDTH-4){1'b0}}, IN_value};
   assign cur       = (state == S_B) ? b : a;
   assign acc       = (cur << 3) + (cur << 1) + digit_ext;
   assign can_add   = (cnt < CW'(MAX_DIGITS));
   assign sum_w     = {1'b0, a} + {1'b0, b};
   assign OUT_state = state;

   always_comb begin
      res     = b;
      res_ovf = 1'b0;
      case (OUT_op)
         3'd1: begin res = sum_w[WIDTH-1:0]; res_ovf = sum_w[WIDTH]; end
         3'd2: begin res = a - b; res_ovf = (a < b); end
         3'd3: res = a & b;
         3'd4: res = a | b;
         3'd5: res = (a > b) ? WIDTH'(1) : ((a == b) ? '0 : '1);
         default: res = b;
      endcase
   end

   always_ff @(posedge IN_clk or negedge IN_rst_n) begin
      if (!IN_rst_n) begin
         state       <= S_A;
         key_d       <= 1'b0;
         a           <= '0;
         b           <= '0;
         cnt         <= '0;
         OUT_display <= '0;
         OUT_op      <= 3'd0;
         OUT_done    <= 1'b0;
         OUT_ovf     <= 1'b0;
      end else if (IN_clr) begin
         state       <= S_A;
         key_d       <= 1'b0;
         a           <= '0;
         b           <= '0;
         cnt         <= '0;
         OUT_display <= '0;
         OUT_op      <= 3'd0;
         OUT_done    <= 1'b0;
         OUT_ovf     <= 1'b0;
      end else begin
         key_d    <= IN_key;
         OUT_done <= 1'b0;
         if (ev) begin
            case (state)
               S_A: begin
                  if (is_digit) begin
                     if (can_add) begin
                        a           <= acc;
                        OUT_display <= acc;
                        cnt         <= cnt + 1'b1;
                     end
                  end else if (!is_eq) begin
                     OUT_op <= new_op;
                     cnt    <= '0;
                     state  <= S_OP;
                  end
               end
               S_OP: begin
                  if (is_digit) begin
                     b           <= digit_ext;
                     OUT_display <= digit_ext;
                     cnt         <= CW'(1);
                     state       <= S_B;
                  end else if (!is_eq) begin
                     OUT_op <= new_op;
                  end
               end
               S_B: begin
                  if (is_digit) begin
                     if (can_add) begin
                        b           <= acc;
                        OUT_display <= acc;
                        cnt         <= cnt + 1'b1;
                     end
                  end else begin
                     // '=' and a chained operator share the computation.
                     a           <= res;
                     b           <= '0;
                     cnt         <= '0;
                     OUT_display <= res;
                     OUT_ovf     <= res_ovf;
                     OUT_done    <= 1'b1;
                     if (is_eq) begin
                        state <= S_RES;
                     end else begin
                        OUT_op <= new_op;
                        state  <= S_OP;
                     end
                  end
               end
               S_RES: begin
                  if (is_digit) begin
                     a           <= digit_ext;
                     OUT_display <= digit_ext;
                     cnt         <= CW'(1);
                     OUT_op      <= 3'd0;
                     OUT_ovf     <= 1'b0;
                     state       <= S_A;
                  end else if (!is_eq) begin
                     OUT_op <= new_op;
                     cnt    <= '0;
                     state  <= S_OP;
                  end
               end
               default: state <= S_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_calc_entry.sv
// Directed bench for key_calc_entry: key sequences with hand-computed display, operator,
// state, overflow and done-pulse expectations.
module tb_key_calc_entry;

   logic        IN_clk;
   logic        IN_rst_n;
   logic [3:0]  IN_value;
   logic        IN_key;
   logic        IN_clr;
   logic [15:0] OUT_display;
   logic [2:0]  OUT_op;
   logic [1:0]  OUT_state;
   logic        OUT_done;
   logic        OUT_ovf;

   int   n_checks;
   int   n_fail;
   int   done_cnt;
   int   done_base;
   logic done_seen;

   localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_AND = 4'd12,
                          K_OR = 4'd13, K_CMP = 4'd14, K_EQ = 4'd15;

   key_calc_entry #(.WIDTH(16), .MAX_DIGITS(4)) dut (
      .IN_clk      (IN_clk),
      .IN_rst_n    (IN_rst_n),
      .IN_value    (IN_value),
      .IN_key      (IN_key),
      .IN_clr      (IN_clr),
      .OUT_display (OUT_display),
      .OUT_op      (OUT_op),
      .OUT_state   (OUT_state),
      .OUT_done    (OUT_done),
      .OUT_ovf     (OUT_ovf)
   );

   // clock / reset
   initial IN_clk = 1'b0;
   always #5 IN_clk = ~IN_clk;

   // done pulses are counted mid-cycle so each one-cycle pulse is seen once
   always @(negedge IN_clk) if (OUT_done) done_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge IN_clk);
      #1;
   endtask

   task automatic press(input logic [3:0] v);
      IN_value = v;
      IN_key   = 1'b1;
      tick();
      done_seen = OUT_done;
      IN_key    = 1'b0;
      tick();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic clear();
      IN_clr = 1'b1;
      tick();
      IN_clr = 1'b0;
      tick();
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      done_cnt  = 0;
      done_seen = 1'b0;
      IN_rst_n  = 1'b0;
      IN_value  = 4'd0;
      IN_key    = 1'b0;
      IN_clr    = 1'b0;
      repeat (2) tick();
      check_eq("reset_display", OUT_display, 0);
      check_eq("reset_state", OUT_state, 0);
      check_eq("reset_op", OUT_op, 0);
      check_eq("reset_ovf", OUT_ovf, 0);
      check_eq("reset_done", OUT_done, 0);
      IN_rst_n = 1'b1;
      tick();

      // rising-edge detection: one event for a long hold, value changes ignored
      IN_value = 4'd7;
      IN_key   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) IN_value = 4'd3;
         tick();
      end
      check_eq("hold_display", OUT_display, 7);
      check_eq("hold_state", OUT_state, 0);
      IN_key = 1'b0;
      tick();
      press(K_ADD);
      check_eq("hold_op_state", OUT_state, 1);
      check_eq("hold_op", OUT_op, 1);
      check_eq("hold_display_a", OUT_display, 7);
      check_eq("hold_no_done", done_cnt, 0);
      clear();
      check_eq("clr_display", OUT_display, 0);
      check_eq("clr_op", OUT_op, 0);

      // add: 12 + 34 = 46
      done_base = done_cnt;
      press(4'd1); press(4'd2);
      check_eq("add_a", OUT_display, 12);
      press(K_ADD); press(4'd3); press(4'd4);
      check_eq("add_b", OUT_display, 34);
      check_eq("add_b_state", OUT_state, 2);
      press(K_EQ);
      check_eq("add_done_pulse", done_seen, 1);
      check_eq("add_result", OUT_display, 46);
      check_eq("add_ovf", OUT_ovf, 0);
      check_eq("add_state", OUT_state, 3);
      check_eq("add_done_count", done_cnt - done_base, 1);

      // subtract with borrow, then chained add
      clear();
      done_base = done_cnt;
      press(4'd5); press(K_SUB); press(4'd9); press(K_ADD);
      check_eq("chain_done_pulse", done_seen, 1);
      check_eq("chain_sub_result", OUT_display, 65532);
      check_eq("chain_sub_ovf", OUT_ovf, 1);
      check_eq("chain_state", OUT_state, 1);
      check_eq("chain_op", OUT_op, 1);
      press(4'd1); press(K_EQ);
      check_eq("chain_final", OUT_display, 65533);
      check_eq("chain_final_ovf", OUT_ovf, 0);
      check_eq("chain_done_count", done_cnt - done_base, 2);

      // digit limit and AND
      clear();
      for (int i = 0; i < 5; i++) press(4'd9);
      check_eq("limit_a", OUT_display, 9999);
      press(K_AND);
      check_eq("and_op", OUT_op, 3);
      press(4'd1); press(4'd2); press(4'd3);
      check_eq("and_b", OUT_display, 123);
      press(K_EQ);
      check_eq("and_result", OUT_display, 11);
      check_eq("and_ovf", OUT_ovf, 0);

      // compare: equal then less-than
      press(4'd4); press(K_CMP); press(4'd4); press(K_EQ);
      check_eq("cmp_eq", OUT_display, 0);
      press(4'd3); press(K_CMP); press(4'd4); press(K_EQ);
      check_eq("cmp_lt", OUT_display, 16'hFFFF);
      press(4'd9); press(K_CMP); press(4'd4); press(K_EQ);
      check_eq("cmp_gt", OUT_display, 1);

      // OR plus an add that carries out: 65535 + 1 via chained result
      clear();
      press(4'd5); press(K_OR); press(4'd1); press(4'd0); press(K_EQ);
      check_eq("or_result", OUT_display, 15);
      clear();
      press(4'd3); press(K_CMP); press(4'd4); press(K_ADD);
      press(4'd1); press(K_EQ);
      check_eq("carry_result", OUT_display, 0);
      check_eq("carry_ovf", OUT_ovf, 1);

      // ignored '=' in each state, result reuse, fresh entry after result
      clear();
      done_base = done_cnt;
      press(K_EQ);
      check_eq("eq_in_a_state", OUT_state, 0);
      check_eq("eq_in_a_done", done_seen, 0);
      press(4'd3); press(K_ADD); press(K_EQ);
      check_eq("eq_in_op_state", OUT_state, 1);
      check_eq("eq_in_op_done", done_seen, 0);
      press(K_SUB);
      check_eq("op_replace", OUT_op, 2);
      press(K_ADD);
      press(4'd2); press(K_EQ);
      check_eq("reuse_first", OUT_display, 5);
      press(K_EQ);
      check_eq("eq_in_res_state", OUT_state, 3);
      check_eq("eq_in_res_display", OUT_display, 5);
      check_eq("eq_in_res_done", done_seen, 0);
      press(K_ADD); press(4'd4); press(K_EQ);
      check_eq("reuse_result", OUT_display, 9);
      check_eq("ignored_done_count", done_cnt - done_base, 2);
      press(4'd6);
      check_eq("fresh_display", OUT_display, 6);
      check_eq("fresh_state", OUT_state, 0);
      check_eq("fresh_op", OUT_op, 0);
      press(4'd1);
      check_eq("fresh_accum", OUT_display, 61);

      // async reset while entering B
      press(K_ADD); press(4'd3);
      check_eq("pre_reset_state", OUT_state, 2);
      #2 IN_rst_n = 1'b0;
      #1;
      check_eq("async_rst_display", OUT_display, 0);
      check_eq("async_rst_state", OUT_state, 0);
      check_eq("async_rst_op", OUT_op, 0);
      tick();
      IN_rst_n = 1'b1;
      tick();

      // clear together with a key event discards the event
      press(4'd7);
      done_base = done_cnt;
      IN_clr   = 1'b1;
      IN_key   = 1'b1;
      IN_value = 4'd8;
      tick();
      check_eq("clr_event_display", OUT_display, 0);
      check_eq("clr_event_state", OUT_state, 0);
      IN_clr = 1'b0;
      IN_key = 1'b0;
      tick();
      press(4'd2);
      check_eq("after_clr_entry", OUT_display, 2);
      check_eq("clr_no_done", done_cnt - done_base, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_calc_entry.md
Name: key_calc_entry

Overview:
- Sits directly downstream of the 4x4 matrix keyboard scanner in the calculator datapath.
- Turns the scanner's level-type key indication and 4-bit key code into discrete press events.
- Assembles decimal operands, latches the operator, and computes the result on '='.
- Drives the display/result path: current operand or result, operator, and a one-cycle done strobe.

Parameters:
- WIDTH, 16, operand/result width in bits.
- MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS must be <= 2^WIDTH.

Ports:
- IN_clk  input  1  system clock, same clock as the scanner.
- IN_rst_n  input  1  asynchronous active-low reset.
- IN_value  input  4  key code from the scanner: 0-9 digit, 10 '+', 11 '-', 12 AND, 13 OR, 14 CMP, 15 '='.
- IN_key  input  1  scanner key-held level; high while a key is pressed.
- IN_clr  input  1  synchronous clear, active high.
- OUT_display  output  WIDTH  operand being entered, or the last result.
- OUT_op  output  3  latched operator: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 cmp.
- OUT_state  output  2  FSM state encoding, listed below.
- OUT_done  output  1  one-cycle pulse when a result is produced.
- OUT_ovf  output  1  carry (add) or borrow (sub) from the last computation.

Behaviour:
- Reset: async when IN_rst_n=0. Outputs: OUT_display=0, OUT_op=0, OUT_state=S_A, OUT_done=0, OUT_ovf=0. Internal: A=B=0, digit count=0, key_d=0.
- Reset mid-operation discards all entry.
- Event detection: key_d registers IN_key each cycle. A press event fires in the cycle where IN_key=1 and key_d=0; IN_value is sampled in that same cycle.
- Held keys produce no further events. Value changes while IN_key stays high are ignored.
- All register/output updates occur one clock after the event cycle.
- IN_clr: acts as reset but synchronously, and wins over a simultaneous event.
- Digit accumulation: X <= X*10 + d, computed as (X<<3)+(X<<1)+d in WIDTH bits. The count increments on each accepted digit.
- Digits beyond MAX_DIGITS are ignored with no state change.
- Leading zeros count toward MAX_DIGITS.
- FSM states: S_A=0 entering A; S_OP=1 operator held, B empty; S_B=2 entering B; S_RES=3 result shown.
- S_A:
  - digit: accumulate into A; display A.
  - operator: latch op, clear count, go S_OP. A is 0 if no digits were entered.
  - '=': ignored.
- S_OP:
  - digit: B=d, count=1, go S_B; display B.
  - operator: replace OUT_op, stay in S_OP.
  - '=': ignored.
- S_B:
  - digit: accumulate into B.
  - '=': R=A op B; A<=R, B<=0, display R, pulse OUT_done, go S_RES.
  - operator (chaining): same computation and done pulse, then latch the new op and go S_OP.
- S_RES:
  - digit: A=d, count=1, OUT_op=0, OUT_ovf=0, go S_A.
  - operator: keep A=R, latch op, go S_OP.
  - '=': ignored, no pulse.
- Arithmetic, unsigned, WIDTH bits:
  - add: sum modulo 2^WIDTH; OUT_ovf = carry out.
  - sub: A-B modulo 2^WIDTH; OUT_ovf = (A<B).
  - and / or: bitwise.
  - cmp: R = 1 if A>B, 0 if A==B, all-ones if A<B.
  - OUT_ovf is cleared for and, or, cmp.
- OUT_done: high for exactly one cycle per computation. It is never asserted by reset, clr, or ignored keys.

Test Plan:
- Rising-edge detection: IN_key high 10 cycles with value 7, from reset -> A=7, OUT_display=7, one update only. Toggling IN_value while held -> no change.
- Add: keys 1,2,'+',3,4,'=' -> OUT_display=46, OUT_done one cycle, OUT_ovf=0, OUT_state=3.
- Sub borrow and chaining: 5,'-',9,'+',1,'=' -> after '+', display 65532 with ovf=1. Final display 65533, ovf=0, two OUT_done pulses.
- Digit limit and logic: 9,9,9,9,9,'&',1,2,3,'=' -> A=9999 (fifth digit ignored), result 9999&123=11. Then cmp: 4,CMP,4,'=' -> 0; 3,CMP,4,'=' -> 16'hFFFF.
- Ignored keys and post-result: '=' in S_A, S_OP, and S_RES -> no state change, no done pulse. Operator in S_RES -> reuses result as A. Digit in S_RES -> starts a fresh A.
- Reset/clear: IN_rst_n low while in S_B -> immediate zeros, S_A. IN_clr together with a key event -> cleared, event discarded.
